// File: rtl/node_resp_collector_pkg.sv
// Shared types and helpers for the response fan-in collector and its arbiter.
package node_resp_pkg;

   typedef enum logic {ST_EMPTY, ST_FULL} coll_state_t;

   localparam int N_CHILD_DEF = 10;
   localparam int DATA_W_DEF  = 16;
   localparam int IDX_W_DEF   = 4;

   // Round-robin successor; wraps at the child count, not at the index width.
   function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/node_resp_collector_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
   parameter int N_CHILD = 10,
   parameter int IDX_W   = 4
) (
   input  logic [N_CHILD-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               en,
   output logic [N_CHILD-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx
);

   int   cand;
   logic found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 0; k < N_CHILD; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N_CHILD) cand = cand - N_CHILD;
         if (en && !found && cand < N_CHILD && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/node_resp_collector.sv
// Fan-in collector: round-robin over child responses into one registered output slot.
// Optional macro NODE_RESP_PARITY_EN adds up_par and par_err_cnt.
module node_resp_collector
   import node_resp_pkg::*;
#(
   parameter int N_CHILD = N_CHILD_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int IDX_W   = IDX_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_CHILD-1:0]          child_valid,
   input  logic [N_CHILD*DATA_W-1:0]   child_data,
   output logic [N_CHILD-1:0]          child_ready,
   output logic                        up_valid,
   output logic [DATA_W-1:0]           up_data,
   output logic [IDX_W-1:0]            up_idx,
   input  logic                        up_ready
`ifdef NODE_RESP_PARITY_EN
   ,
   output logic                        up_par,
   output logic [7:0]                  par_err_cnt
`endif
);

   coll_state_t       state, state_nxt;
   logic [IDX_W-1:0]  rr_ptr, ptr_nxt;
   logic [N_CHILD-1:0] gnt;
   logic [IDX_W-1:0]  gnt_idx;
   logic [DATA_W-1:0] sel_data;
   logic              load_ok;
   logic              load;

   // The slot can take a new word when empty or when it is drained this same cycle.
   assign load_ok = (state == ST_EMPTY) || up_ready;

   rr_arbiter #(
      .N_CHILD (N_CHILD),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req     (child_valid),
      .ptr     (rr_ptr),
      .en      (load_ok && !rst),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign child_ready = gnt;
   assign sel_data    = child_data[gnt_idx*DATA_W +: DATA_W];
   assign up_valid    = (state == ST_FULL);

   always_comb begin
      state_nxt = state;
      ptr_nxt   = rr_ptr;
      load      = 1'b0;
      if (|gnt) begin
         load      = 1'b1;
         state_nxt = ST_FULL;
         ptr_nxt   = IDX_W'(next_idx(32'(gnt_idx), N_CHILD));
      end else if (state == ST_FULL && up_ready) begin
         state_nxt = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_EMPTY;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= ptr_nxt;
      end
   end

   // Output register: data and index only change on a load, so they persist after a drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_data <= '0;
         up_idx  <= '0;
      end else if (load) begin
         up_data <= sel_data;
         up_idx  <= gnt_idx;
      end
   end

`ifdef NODE_RESP_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_par      <= 1'b0;
         par_err_cnt <= '0;
      end else if (load) begin
         up_par <= ^{gnt_idx, sel_data};
         if ((^sel_data) && par_err_cnt != 8'hFF)
            par_err_cnt <= par_err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_node_resp_collector.sv
// Scoreboard bench for node_resp_collector: directed stimulus pushes expected words, a monitor pops them.
module tb_node_resp_collector;

   localparam int N  = 10;
   localparam int DW = 16;
   localparam int IW = 4;

   logic              clk;
   logic              rst;
   logic [N-1:0]      child_valid;
   logic [N*DW-1:0]   child_data;
   logic [N-1:0]      child_ready;
   logic              up_valid;
   logic [DW-1:0]     up_data;
   logic [IW-1:0]     up_idx;
   logic              up_ready;
`ifdef NODE_RESP_PARITY_EN
   logic              up_par;
   logic [7:0]        par_err_cnt;
   logic [7:0]        cnt0;
`endif

   int total = 0;
   int bad   = 0;
   logic [DW+IW-1:0] sb[$];

   node_resp_collector #(.N_CHILD(N), .DATA_W(DW), .IDX_W(IW)) dut (
      .clk         (clk),
      .rst         (rst),
      .child_valid (child_valid),
      .child_data  (child_data),
      .child_ready (child_ready),
      .up_valid    (up_valid),
      .up_data     (up_data),
      .up_idx      (up_idx),
      .up_ready    (up_ready)
`ifdef NODE_RESP_PARITY_EN
      ,
      .up_par      (up_par),
      .par_err_cnt (par_err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [DW-1:0] v);
      child_data[i*DW +: DW] = v;
   endtask

   task automatic expect_word(input logic [DW-1:0] d, input logic [IW-1:0] i);
      sb.push_back({d, i});
   endtask

   // Monitor: every completed upstream handshake must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && up_valid && up_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_word", {12'h0, up_idx, up_data}, 32'hFFFF_FFFF);
         end else begin
            logic [DW+IW-1:0] e;
            e = sb.pop_front();
            check("sb_data", 32'(up_data), 32'(e[DW+IW-1:IW]));
            check("sb_idx",  32'(up_idx),  32'(e[IW-1:0]));
         end
      end
   end

   initial begin
      rst         = 1'b1;
      child_valid = '0;
      child_data  = '0;
      up_ready    = 1'b0;
      #2;
      check("rst_up_valid", 32'(up_valid), 0);
      check("rst_up_data",  32'(up_data), 0);
      check("rst_up_idx",   32'(up_idx), 0);
      step();
      rst = 1'b0;

      // Load 0xBEEF from child 5 and hold it, then reset mid-transfer.
      step();
      child_valid = N'(1 << 5);
      set_data(5, 16'hBEEF);
      #1;
      check("beef_ready", 32'(child_ready), 32'h020);
      step();
      child_valid = '0;
      check("beef_valid", 32'(up_valid), 1);
      check("beef_data",  32'(up_data), 32'hBEEF);
      check("beef_idx",   32'(up_idx), 5);
      #2;
      rst = 1'b1;
      child_valid = N'((1 << 3) | (1 << 8));
      set_data(3, 16'h0303);
      set_data(8, 16'h0808);
      #1;
      check("arst_up_valid",    32'(up_valid), 0);
      check("arst_up_data",     32'(up_data), 0);
      check("arst_up_idx",      32'(up_idx), 0);
      check("arst_child_ready", 32'(child_ready), 0);
      step();
      rst = 1'b0;
      up_ready = 1'b1;
      #1;
      check("post_rst_grant", 32'(child_ready), 32'h008);
      expect_word(16'h0303, 4'd3);
      step();
      child_valid = '0;

      // Single child 7.
      step();
      child_valid = N'(1 << 7);
      set_data(7, 16'h1234);
      #1;
      check("single_ready", 32'(child_ready), 32'h080);
      expect_word(16'h1234, 4'd7);
      step();
      child_valid = '0;
      check("single_valid", 32'(up_valid), 1);
      step();
      check("single_drain", 32'(up_valid), 0);

      // Wrap: park rr_ptr at 9 by granting child 8, then offer 9 and 0.
      child_valid = N'(1 << 8);
      #1;
      check("wrap_pre_ready", 32'(child_ready), 32'h100);
      expect_word(16'h0808, 4'd8);
      step();
      child_valid = N'((1 << 9) | 1);
      set_data(9, 16'h0909);
      set_data(0, 16'h0A00);
      #1;
      check("wrap_ready9", 32'(child_ready), 32'h200);
      expect_word(16'h0909, 4'd9);
      step();
      child_valid = N'(1);
      #1;
      check("wrap_ready0", 32'(child_ready), 32'h001);
      expect_word(16'h0A00, 4'd0);
      step();
      child_valid = N'(3);
      set_data(1, 16'h0B01);
      #1;
      check("wrap_ptr_is_1", 32'(child_ready), 32'h002);
      expect_word(16'h0B01, 4'd1);
      step();
      // Grant child 9 alone so the pointer lands back on 0.
      child_valid = N'(1 << 9);
      #1;
      check("ptr_to_0_ready", 32'(child_ready), 32'h200);
      expect_word(16'h0909, 4'd9);
      step();

      // All ten children continuously valid: order 0..9,0,1 with no bubble.
      for (int i = 0; i < N; i++) set_data(i, 16'(16'h0100 + i));
      child_valid = '1;
      for (int k = 0; k < 12; k++) begin
         #1;
         check("all_ready", 32'(child_ready), 32'(1 << (k % N)));
         expect_word(16'(16'h0100 + (k % N)), IW'(k % N));
         step();
         check("all_no_bubble", 32'(up_valid), 1);
      end
      child_valid = '0;

      // Backpressure: child 3 held for 5 cycles while child 4 waits.
      set_data(3, 16'h0333);
      set_data(4, 16'h0444);
      child_valid = N'(1 << 3);
      #1;
      check("bp_ready3", 32'(child_ready), 32'h008);
      expect_word(16'h0333, 4'd3);
      step();
      child_valid = N'(1 << 4);
      up_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_ready_zero", 32'(child_ready), 0);
         check("bp_idx_held",   32'(up_idx), 3);
         check("bp_data_held",  32'(up_data), 32'h0333);
         check("bp_valid_held", 32'(up_valid), 1);
         step();
      end
      up_ready = 1'b1;
      #1;
      check("bp_ready4", 32'(child_ready), 32'h010);
      expect_word(16'h0444, 4'd4);
      step();
      child_valid = '0;
      check("bp_idx4", 32'(up_idx), 4);
      step();

`ifdef NODE_RESP_PARITY_EN
      cnt0 = par_err_cnt;
      child_valid = N'(1 << 2);
      set_data(2, 16'h0001);
      #1;
      check("par_ready2", 32'(child_ready), 32'h004);
      expect_word(16'h0001, 4'd2);
      step();
      child_valid = '0;
      check("par_bit", 32'(up_par), 0);
      check("par_cnt", 32'(par_err_cnt), 32'(8'(cnt0 + 8'd1)));
      step();
`endif

      repeat (3) step();
      check("sb_empty", 32'(sb.size()), 0);
      check("idle_valid", 32'(up_valid), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
